// File: rtl/config_register_controller_pkg.sv
// Shared types and constants for the configuration register write-port controller.
package config_register_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } ctrlState_e;

   localparam logic REQ_NOC  = 1'b0;
   localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/config_register_controller_arb.sv
// Two-input round-robin arbiter; the port not served last wins a tie.
module rr_arbiter_2
   import config_register_ctrl_pkg::*;
(
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       enable_i,
   input  logic [1:0] valid_i,
   output logic [1:0] grant_o
);

   logic lastServed_q;
   logic lastServed_d;

   always_comb begin
      grant_o      = 2'b00;
      lastServed_d = lastServed_q;
      if (enable_i) begin
         if (valid_i[REQ_NOC] && (!valid_i[REQ_HOST] || lastServed_q == REQ_HOST)) begin
            grant_o[REQ_NOC] = 1'b1;
            lastServed_d     = REQ_NOC;
         end else if (valid_i[REQ_HOST]) begin
            grant_o[REQ_HOST] = 1'b1;
            lastServed_d      = REQ_HOST;
         end
      end
   end

   // Reset favours the NoC port on the first contention.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         lastServed_q <= REQ_HOST;
      end else begin
         lastServed_q <= lastServed_d;
      end
   end

endmodule

// File: rtl/config_register_controller.sv
// Write-port controller for the NoC configuration register bank: arbitration plus clear sequencer.
// Define CFG_REG_CTRL_PROTECT_EN to reject host writes below PROTECT_LIMIT.
module config_register_controller
   import config_register_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 12,
   parameter int                    ADDR_WIDTH    = 6,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0,
   parameter int                    PROTECT_LIMIT = 8
) (
   input  logic                  clock__i,
   input  logic                  reset__i,
   input  logic                  Req0_valid___i,
   input  logic [ADDR_WIDTH-1:0] Req0_address_i,
   input  logic [DATA_WIDTH-1:0] Req0_data____i,
   output logic                  Req0_ready___o,
   input  logic                  Req1_valid___i,
   input  logic [ADDR_WIDTH-1:0] Req1_address_i,
   input  logic [DATA_WIDTH-1:0] Req1_data____i,
   output logic                  Req1_ready___o,
   input  logic                  Clear_start__i,
   output logic                  Busy_________o,
   output logic                  Clear_done___o,
   output logic                  Req1_error___o,
   output logic                  Write_enable_o,
   output logic [ADDR_WIDTH-1:0] Write_addres_o,
   output logic [DATA_WIDTH-1:0] Write_data___o
);

`ifdef CFG_REG_CTRL_PROTECT_EN
   localparam bit ProtectEn = 1'b1;
`else
   localparam bit ProtectEn = 1'b0;
`endif

   localparam logic [ADDR_WIDTH:0] LastAddr  = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
   localparam logic [ADDR_WIDTH:0] ProtLimit = (ADDR_WIDTH+1)'(PROTECT_LIMIT);

   ctrlState_e            state_q, state_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  writeEn_q, writeEn_d;
   logic [ADDR_WIDTH-1:0] writeAddr_q, writeAddr_d;
   logic [DATA_WIDTH-1:0] writeData_q, writeData_d;
   logic                  reqError_q, reqError_d;
   logic [1:0]            grant;
   logic                  arbEnable;
   logic                  hostBlocked;

   // Clear and reset both pre-empt arbitration, so no handshake completes in those cycles.
   assign arbEnable   = (state_q == IDLE) && !Clear_start__i && !reset__i;
   assign hostBlocked = ProtectEn && ({1'b0, Req1_address_i} < ProtLimit);

   rr_arbiter_2 u_arb (
      .clock_i  (clock__i),
      .reset_i  (reset__i),
      .enable_i (arbEnable),
      .valid_i  ({Req1_valid___i, Req0_valid___i}),
      .grant_o  (grant)
   );

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      writeEn_d   = 1'b0;
      writeAddr_d = writeAddr_q;
      writeData_d = writeData_q;
      reqError_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (Clear_start__i) begin
               state_d = CLEAR;
               count_d = '0;
            end else if (grant[REQ_NOC]) begin
               writeEn_d   = 1'b1;
               writeAddr_d = Req0_address_i;
               writeData_d = Req0_data____i;
            end else if (grant[REQ_HOST]) begin
               if (hostBlocked) begin
                  reqError_d = 1'b1;
               end else begin
                  writeEn_d   = 1'b1;
                  writeAddr_d = Req1_address_i;
                  writeData_d = Req1_data____i;
               end
            end
         end
         CLEAR: begin
            writeEn_d   = 1'b1;
            writeAddr_d = count_q[ADDR_WIDTH-1:0];
            writeData_d = CLEAR_VALUE;
            count_d     = count_q + 1'b1;
            if (count_q == LastAddr) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset lands in CLEAR so the bank is always wiped after power-up or a reset.
   always_ff @(posedge clock__i) begin
      if (reset__i) begin
         state_q     <= CLEAR;
         count_q     <= '0;
         writeEn_q   <= 1'b0;
         writeAddr_q <= '0;
         writeData_q <= '0;
         reqError_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         writeEn_q   <= writeEn_d;
         writeAddr_q <= writeAddr_d;
         writeData_q <= writeData_d;
         reqError_q  <= reqError_d;
      end
   end

   assign Req0_ready___o = grant[REQ_NOC];
   assign Req1_ready___o = grant[REQ_HOST];
   assign Busy_________o = (state_q != IDLE);
   assign Clear_done___o = (state_q == DONE);
   assign Req1_error___o = reqError_q;
   assign Write_enable_o = writeEn_q;
   assign Write_addres_o = writeAddr_q;
   assign Write_data___o = writeData_q;

endmodule

// File: tb/tb_config_register_controller.sv
// Directed self-checking bench for config_register_controller (default parameters, AW=6).
module tb_config_register_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0Valid, req1Valid, clearStart;
   logic [5:0]  req0Addr, req1Addr;
   logic [11:0] req0Data, req1Data;
   logic        req0Ready, req1Ready, busy, clearDone, req1Error, writeEn;
   logic [5:0]  writeAddr;
   logic [11:0] writeData;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   config_register_controller dut (
      .clock__i       (clock),
      .reset__i       (reset),
      .Req0_valid___i (req0Valid),
      .Req0_address_i (req0Addr),
      .Req0_data____i (req0Data),
      .Req0_ready___o (req0Ready),
      .Req1_valid___i (req1Valid),
      .Req1_address_i (req1Addr),
      .Req1_data____i (req1Data),
      .Req1_ready___o (req1Ready),
      .Clear_start__i (clearStart),
      .Busy_________o (busy),
      .Clear_done___o (clearDone),
      .Req1_error___o (req1Error),
      .Write_enable_o (writeEn),
      .Write_addres_o (writeAddr),
      .Write_data___o (writeData)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; clearStart = 1'b0;
      req0Valid = 1'b0; req0Addr = 6'd0; req0Data = 12'h000;
      req1Valid = 1'b0; req1Addr = 6'd0; req1Data = 12'h000;
      step(); step();
      reset = 1'b0;
      req0Valid = 1'b1; req0Addr = 6'd7; req0Data = 12'h777;
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy actual=%0b expected=1", busy); end
      checks++; if (writeEn !== 1'b0 || writeAddr !== 6'd0 || writeData !== 12'h000) begin failures++; $display("[TB] FAIL reset_write actual=%0b/%0d/%h expected=0/0/000", writeEn, writeAddr, writeData); end
      checks++; if (clearDone !== 1'b0 || req1Error !== 1'b0 || req0Ready !== 1'b0 || req1Ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags done=%0b err=%0b r0=%0b r1=%0b expected all 0", clearDone, req1Error, req0Ready, req1Ready); end
      for (int i = 0; i < 64; i++) begin
         step();
         checks++; if (writeEn !== 1'b1 || writeAddr !== 6'(i) || writeData !== 12'h000) begin failures++; $display("[TB] FAIL reset_clear_write actual=%0b/%0d/%h expected=1/%0d/000", writeEn, writeAddr, writeData, i); end
         checks++; if (busy !== 1'b1 || req0Ready !== 1'b0 || clearDone !== (i == 63)) begin failures++; $display("[TB] FAIL reset_clear_flags busy=%0b r0=%0b done=%0b expected busy=1 r0=0 done=%0b", busy, req0Ready, clearDone, i == 63); end
      end
      step();
      checks++; if (busy !== 1'b0 || clearDone !== 1'b0 || writeEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle busy=%0b done=%0b we=%0b expected 0/0/0", busy, clearDone, writeEn); end
      checks++; if (req0Ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_first_grant actual=%0b expected=1", req0Ready); end
      step();
      req0Valid = 1'b0;
      #1;
      checks++; if (writeEn !== 1'b1 || writeAddr !== 6'd7 || writeData !== 12'h777) begin failures++; $display("[TB] FAIL reset_first_write actual=%0b/%0d/%h expected=1/7/777", writeEn, writeAddr, writeData); end
      step();
   endtask

   task automatic test_single_host();
      req1Valid = 1'b1; req1Addr = 6'd5; req1Data = 12'hABC;
      #1;
      checks++; if (req1Ready !== 1'b1 || req0Ready !== 1'b0) begin failures++; $display("[TB] FAIL host_ready r1=%0b r0=%0b expected r1=1 r0=0", req1Ready, req0Ready); end
      step();
      req1Valid = 1'b0;
      #1;
      checks++; if (writeEn !== 1'b1 || writeAddr !== 6'd5 || writeData !== 12'hABC) begin failures++; $display("[TB] FAIL host_write actual=%0b/%0d/%h expected=1/5/abc", writeEn, writeAddr, writeData); end
      checks++; if (req1Error !== 1'b0) begin failures++; $display("[TB] FAIL host_error actual=%0b expected=0", req1Error); end
      step();
      checks++; if (writeEn !== 1'b0 || writeAddr !== 6'd5 || writeData !== 12'hABC) begin failures++; $display("[TB] FAIL host_hold actual=%0b/%0d/%h expected=0/5/abc", writeEn, writeAddr, writeData); end
   endtask

   task automatic test_back_to_back();
      req0Valid = 1'b1; req0Addr = 6'd1; req0Data = 12'h111;
      req1Valid = 1'b1; req1Addr = 6'd2; req1Data = 12'h222;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (req0Ready !== (k % 2 == 0) || req1Ready !== (k % 2 == 1)) begin failures++; $display("[TB] FAIL rr_grant%0d r0=%0b r1=%0b expected r0=%0b r1=%0b", k, req0Ready, req1Ready, k % 2 == 0, k % 2 == 1); end
         step();
         checks++; if (writeEn !== 1'b1 || writeAddr !== ((k % 2 == 0) ? 6'd1 : 6'd2) || writeData !== ((k % 2 == 0) ? 12'h111 : 12'h222)) begin failures++; $display("[TB] FAIL rr_write%0d actual=%0b/%0d/%h expected port %0d", k, writeEn, writeAddr, writeData, k % 2); end
      end
   endtask

   task automatic test_clear_start();
      clearStart = 1'b1;
      #1;
      checks++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL clr_start_priority r0=%0b r1=%0b busy=%0b expected 0/0/0", req0Ready, req1Ready, busy); end
      step();
      clearStart = 1'b0;
      #1;
      checks++; if (busy !== 1'b1 || writeEn !== 1'b0) begin failures++; $display("[TB] FAIL clr_enter busy=%0b we=%0b expected 1/0", busy, writeEn); end
      for (int i = 0; i < 64; i++) begin
         step();
         checks++; if (writeEn !== 1'b1 || writeAddr !== 6'(i) || writeData !== 12'h000 || req0Ready !== 1'b0 || req1Ready !== 1'b0) begin failures++; $display("[TB] FAIL clr_walk actual=%0b/%0d/%h r0=%0b r1=%0b expected=1/%0d/000 r=0", writeEn, writeAddr, writeData, req0Ready, req1Ready, i); end
      end
      checks++; if (clearDone !== 1'b1) begin failures++; $display("[TB] FAIL clr_done actual=%0b expected=1", clearDone); end
      step();
      checks++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin failures++; $display("[TB] FAIL clr_resume r0=%0b r1=%0b expected 1/0", req0Ready, req1Ready); end
      step();
      checks++; if (writeEn !== 1'b1 || writeAddr !== 6'd1 || writeData !== 12'h111 || req1Ready !== 1'b1) begin failures++; $display("[TB] FAIL clr_resume_w0 actual=%0b/%0d/%h r1=%0b expected=1/1/111 r1=1", writeEn, writeAddr, writeData, req1Ready); end
      req0Valid = 1'b0;
      step();
      req1Valid = 1'b0;
      #1;
      checks++; if (writeEn !== 1'b1 || writeAddr !== 6'd2 || writeData !== 12'h222) begin failures++; $display("[TB] FAIL clr_resume_w1 actual=%0b/%0d/%h expected=1/2/222", writeEn, writeAddr, writeData); end
      step();
   endtask

   task automatic test_reset_midclear();
      clearStart = 1'b1;
      step();
      clearStart = 1'b0;
      repeat (20) step();
      checks++; if (writeEn !== 1'b1 || writeAddr !== 6'd19) begin failures++; $display("[TB] FAIL mid_progress actual=%0b/%0d expected=1/19", writeEn, writeAddr); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checks++; if (writeEn !== 1'b0 || writeAddr !== 6'd0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset actual=%0b/%0d busy=%0b expected=0/0 busy=1", writeEn, writeAddr, busy); end
      for (int i = 0; i < 64; i++) begin
         step();
         checks++; if (writeEn !== 1'b1 || writeAddr !== 6'(i) || clearDone !== (i == 63)) begin failures++; $display("[TB] FAIL mid_walk actual=%0b/%0d done=%0b expected=1/%0d done=%0b", writeEn, writeAddr, clearDone, i, i == 63); end
      end
      step();
      checks++; if (busy !== 1'b0 || writeEn !== 1'b0) begin failures++; $display("[TB] FAIL mid_idle busy=%0b we=%0b expected 0/0", busy, writeEn); end
   endtask

   task automatic test_protect();
      req1Valid = 1'b1; req1Addr = 6'd3; req1Data = 12'h5A5;
      #1;
      checks++; if (req1Ready !== 1'b1) begin failures++; $display("[TB] FAIL prot_low_ready actual=%0b expected=1", req1Ready); end
      step();
      req1Valid = 1'b0;
      #1;
`ifdef CFG_REG_CTRL_PROTECT_EN
      checks++; if (writeEn !== 1'b0 || req1Error !== 1'b1) begin failures++; $display("[TB] FAIL prot_low_blocked we=%0b err=%0b expected 0/1", writeEn, req1Error); end
`else
      checks++; if (writeEn !== 1'b1 || writeAddr !== 6'd3 || writeData !== 12'h5A5 || req1Error !== 1'b0) begin failures++; $display("[TB] FAIL prot_off_write actual=%0b/%0d/%h err=%0b expected=1/3/5a5 err=0", writeEn, writeAddr, writeData, req1Error); end
`endif
      step();
      checks++; if (req1Error !== 1'b0) begin failures++; $display("[TB] FAIL prot_err_pulse actual=%0b expected=0", req1Error); end
      req1Valid = 1'b1; req1Addr = 6'd8; req1Data = 12'h888;
      step();
      req1Valid = 1'b0;
      #1;
      checks++; if (writeEn !== 1'b1 || writeAddr !== 6'd8 || writeData !== 12'h888 || req1Error !== 1'b0) begin failures++; $display("[TB] FAIL prot_limit_write actual=%0b/%0d/%h err=%0b expected=1/8/888 err=0", writeEn, writeAddr, writeData, req1Error); end
      req0Valid = 1'b1; req0Addr = 6'd3; req0Data = 12'h333;
      step();
      req0Valid = 1'b0;
      #1;
      checks++; if (writeEn !== 1'b1 || writeAddr !== 6'd3 || writeData !== 12'h333 || req1Error !== 1'b0) begin failures++; $display("[TB] FAIL prot_noc_write actual=%0b/%0d/%h err=%0b expected=1/3/333 err=0", writeEn, writeAddr, writeData, req1Error); end
      step();
   endtask

   initial begin
      test_reset();
      test_single_host();
      test_back_to_back();
      test_clear_start();
      test_reset_midclear();
      test_protect();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
